// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MIPS multi-cycle controller: states, instruction
// classes, opcode/funct values and datapath mux select codes.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_EXEC_R   = 4'd2,
        ST_EXEC_I   = 4'd3,
        ST_MEM_ADDR = 4'd4,
        ST_MEM_RD   = 4'd5,
        ST_MEM_WR   = 4'd6,
        ST_WB_MEM   = 4'd7,
        ST_WB_ALU   = 4'd8,
        ST_BRANCH   = 4'd9,
        ST_JUMP     = 4'd10,
        ST_MULDIV   = 4'd11,
        ST_HALT     = 4'd12
    } state_t;

    typedef enum logic [3:0] {
        CLS_ILLEGAL, CLS_ALU_R, CLS_ALU_I, CLS_LOAD, CLS_STORE, CLS_BRANCH,
        CLS_J, CLS_JAL, CLS_JR, CLS_SYSCALL, CLS_MULDIV
    } instr_class_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BGEZ  = 6'b000001;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BLEZ  = 6'b000110;
    localparam logic [5:0] OP_BGTZ  = 6'b000111;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_SYSCALL = 6'b001100;
    localparam logic [5:0] FN_MULT    = 6'b011000;
    localparam logic [5:0] FN_DIV     = 6'b011010;

    localparam logic [1:0] PCSRC_ALU  = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP = 2'b10;
    localparam logic [1:0] PCSRC_RS   = 2'b11;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_SUB    = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;
    localparam logic [1:0] ALUOP_OPCODE = 2'b11;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] DST_RT = 2'b00;
    localparam logic [1:0] DST_RD = 2'b01;
    localparam logic [1:0] DST_RA = 2'b10;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LEZ = 3'b010;
    localparam logic [2:0] BR_GTZ = 3'b011;
    localparam logic [2:0] BR_GEZ = 3'b100;

endpackage

// File: rtl/mips_instr_classify.sv
// Combinational opcode/funct decoder producing the instruction class, branch
// condition and byte-access flag. MULT/DIV are legal only with MIPS_MULDIV_EN.
module mips_instr_classify
    import mips_ctrl_pkg::*;
(
    input  logic [5:0]   opcode,
    input  logic [5:0]   funct,
    output instr_class_t cls,
    output logic [2:0]   br_cond,
    output logic         mem_byte
);

    always_comb begin
        cls      = CLS_ILLEGAL;
        br_cond  = BR_EQ;
        mem_byte = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_JR:          cls = CLS_JR;
                    FN_SYSCALL:     cls = CLS_SYSCALL;
`ifdef MIPS_MULDIV_EN
                    FN_MULT, FN_DIV: cls = CLS_MULDIV;
`else
                    FN_MULT, FN_DIV: cls = CLS_ILLEGAL;
`endif
                    default:        cls = CLS_ALU_R;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI:
                cls = CLS_ALU_I;
            OP_LW: cls = CLS_LOAD;
            OP_LB: begin cls = CLS_LOAD;  mem_byte = 1'b1; end
            OP_SW: cls = CLS_STORE;
            OP_SB: begin cls = CLS_STORE; mem_byte = 1'b1; end
            OP_BEQ:  begin cls = CLS_BRANCH; br_cond = BR_EQ;  end
            OP_BNE:  begin cls = CLS_BRANCH; br_cond = BR_NE;  end
            OP_BLEZ: begin cls = CLS_BRANCH; br_cond = BR_LEZ; end
            OP_BGTZ: begin cls = CLS_BRANCH; br_cond = BR_GTZ; end
            OP_BGEZ: begin cls = CLS_BRANCH; br_cond = BR_GEZ; end
            OP_J:    cls = CLS_J;
            OP_JAL:  cls = CLS_JAL;
            default: cls = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: fetch/decode/execute/memory/writeback strobes.
// Define MIPS_MULDIV_EN to add the MULT/DIV handshake (md_start/md_done).
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
`ifdef MIPS_MULDIV_EN
    input  logic       md_done,
    output logic       md_start,
`endif
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_source,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_byte,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [2:0] br_cond,
    output logic       retire,
    output logic       illegal,
    output logic       halted,
    output logic [3:0] state
);

    state_t       state_q, state_d;
    instr_class_t dec_cls, cls_q;
    logic [2:0]   dec_br, br_q;
    logic         dec_byte, byte_q;

    mips_instr_classify u_classify (
        .opcode   (opcode),
        .funct    (funct),
        .cls      (dec_cls),
        .br_cond  (dec_br),
        .mem_byte (dec_byte)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            cls_q   <= CLS_ILLEGAL;
            br_q    <= BR_EQ;
            byte_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_DECODE) begin
                cls_q  <= dec_cls;
                br_q   <= dec_br;
                byte_q <= dec_byte;
            end
        end
    end

`ifdef MIPS_MULDIV_EN
    // Set after the first MULDIV cycle so md_start pulses once per instruction.
    logic md_busy;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) md_busy <= 1'b0;
        else        md_busy <= (state_q == ST_MULDIV) && (state_d == ST_MULDIV);
    end
`endif

    assign state = state_q;

    always_comb begin
        state_d       = state_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = PCSRC_ALU;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_byte      = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = DST_RT;
        mem_to_reg    = M2R_ALUOUT;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_RT;
        alu_op        = ALUOP_ADD;
        br_cond       = BR_EQ;
        retire        = 1'b0;
        illegal       = 1'b0;
        halted        = 1'b0;
`ifdef MIPS_MULDIV_EN
        md_start      = 1'b0;
`endif
        case (state_q)
            ST_FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    state_d   = ST_DECODE;
                end
            end
            ST_DECODE: begin
                alu_src_b = SRCB_IMM_SH;
                case (dec_cls)
                    CLS_ALU_R:   state_d = ST_EXEC_R;
                    CLS_ALU_I:   state_d = ST_EXEC_I;
                    CLS_LOAD,
                    CLS_STORE:   state_d = ST_MEM_ADDR;
                    CLS_BRANCH:  state_d = ST_BRANCH;
                    CLS_J, CLS_JAL, CLS_JR: state_d = ST_JUMP;
                    CLS_SYSCALL: state_d = ST_HALT;
                    CLS_MULDIV:  state_d = ST_MULDIV;
                    default: begin
                        illegal = 1'b1;
                        state_d = ST_FETCH;
                    end
                endcase
            end
            ST_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
                state_d   = ST_WB_ALU;
            end
            ST_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_OPCODE;
                state_d   = ST_WB_ALU;
            end
            ST_WB_ALU: begin
                reg_write = 1'b1;
                reg_dst   = (cls_q == CLS_ALU_R) ? DST_RD : DST_RT;
                retire    = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = (cls_q == CLS_STORE) ? ST_MEM_WR : ST_MEM_RD;
            end
            ST_MEM_RD: begin
                i_or_d   = 1'b1;
                mem_read = 1'b1;
                mem_byte = byte_q;
                if (mem_ready) state_d = ST_WB_MEM;
            end
            ST_MEM_WR: begin
                i_or_d    = 1'b1;
                mem_write = 1'b1;
                mem_byte  = byte_q;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = M2R_MDR;
                retire     = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALUOP_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
                br_cond       = br_q;
                retire        = 1'b1;
                state_d       = ST_FETCH;
            end
            ST_JUMP: begin
                pc_write  = 1'b1;
                retire    = 1'b1;
                pc_source = (cls_q == CLS_JR) ? PCSRC_RS : PCSRC_JUMP;
                if (cls_q == CLS_JAL) begin
                    reg_write  = 1'b1;
                    reg_dst    = DST_RA;
                    mem_to_reg = M2R_PC;
                end
                state_d = ST_FETCH;
            end
            ST_MULDIV: begin
`ifdef MIPS_MULDIV_EN
                md_start = !md_busy;
                if (md_busy && md_done) begin
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end
`else
                state_d = ST_FETCH;
`endif
            end
            ST_HALT: halted = 1'b1;
            default: state_d = ST_FETCH;
        endcase
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed self-checking bench for mips_multicycle_ctrl; covers the
// MIPS_MULDIV_EN handshake when that macro is defined.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode, funct;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_byte;
    logic       ir_write, reg_write, alu_src_a, retire, illegal, halted;
    logic [1:0] pc_source, reg_dst, mem_to_reg, alu_src_b, alu_op;
    logic [2:0] br_cond;
    logic [3:0] state;
`ifdef MIPS_MULDIV_EN
    logic       md_done, md_start;
`endif

    int nvec = 0;
    int nerr = 0;
    int ir_cnt = 0;
    int ir_base;

    always #5 clk = ~clk;
    always @(posedge clk) if (ir_write) ir_cnt++;

    mips_multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
        .mem_ready(mem_ready),
`ifdef MIPS_MULDIV_EN
        .md_done(md_done), .md_start(md_start),
`endif
        .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .pc_source(pc_source), .i_or_d(i_or_d), .mem_read(mem_read),
        .mem_write(mem_write), .mem_byte(mem_byte), .ir_write(ir_write),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .br_cond(br_cond), .retire(retire), .illegal(illegal),
        .halted(halted), .state(state)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance to 1ns after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one zero-wait FETCH cycle; leaves the DUT in DECODE
    task automatic fetch(input string tag);
        mem_ready = 1'b1;
        #1;
        chk({tag, "_fetch_state"}, state, 4'd0);
        chk({tag, "_fetch_irw"}, ir_write, 1'b1);
        tick();
    endtask

    initial begin
        rst_n = 1'b0; mem_ready = 1'b0; opcode = '0; funct = '0;
`ifdef MIPS_MULDIV_EN
        md_done = 1'b0;
`endif
        #3;
        chk("rst_state", state, 4'd0);
        chk("rst_mem_read", mem_read, 1'b1);
        chk("rst_ir_write", ir_write, 1'b0);
        chk("rst_pc_write", pc_write, 1'b0);
        chk("rst_retire", retire, 1'b0);
        chk("rst_alu_src_b", alu_src_b, 2'b00);
        @(negedge clk); rst_n = 1'b1;
        tick();

        // ADD: 4 cycles, opcode/funct changed after DECODE to prove latching
        chk("add_fetch_srcb0", alu_src_b, 2'b00);
        mem_ready = 1'b1; #1;
        chk("add_fetch_srcb", alu_src_b, 2'b01);
        chk("add_fetch_pcw", pc_write, 1'b1);
        tick();
        opcode = 6'b000000; funct = 6'b100000; #1;
        chk("add_decode", state, 4'd1);
        chk("add_dec_srcb", alu_src_b, 2'b11);
        tick();
        opcode = 6'b001000; funct = 6'b000000; #1;
        chk("add_exec_r", state, 4'd2);
        chk("add_exec_aluop", alu_op, 2'b10);
        chk("add_exec_srca", alu_src_a, 1'b1);
        tick(); #1;
        chk("add_wb", state, 4'd8);
        chk("add_wb_regw", reg_write, 1'b1);
        chk("add_wb_dst", reg_dst, 2'b01);
        chk("add_wb_retire", retire, 1'b1);
        tick(); #1;
        chk("add_back_fetch", state, 4'd0);
        chk("add_retire_clear", retire, 1'b0);

        // LW with 2 FETCH waits and 1 MEM_RD wait: 8 cycles
        ir_base = ir_cnt;
        mem_ready = 1'b0; #1;
        chk("lw_wait1_irw", ir_write, 1'b0);
        tick(); #1;
        chk("lw_wait2_state", state, 4'd0);
        tick();
        fetch("lw");
        opcode = 6'b100011; #1;
        chk("lw_decode", state, 4'd1);
        tick(); #1;
        chk("lw_mem_addr", state, 4'd4);
        chk("lw_addr_srcb", alu_src_b, 2'b10);
        tick();
        mem_ready = 1'b0; #1;
        chk("lw_mem_rd", state, 4'd5);
        chk("lw_rd_iord", i_or_d, 1'b1);
        chk("lw_rd_memread", mem_read, 1'b1);
        chk("lw_rd_byte", mem_byte, 1'b0);
        tick();
        mem_ready = 1'b1; #1;
        chk("lw_mem_rd2", state, 4'd5);
        chk("lw_rd_noretire", retire, 1'b0);
        tick(); #1;
        chk("lw_wb_mem", state, 4'd7);
        chk("lw_m2r", mem_to_reg, 2'b01);
        chk("lw_regw", reg_write, 1'b1);
        chk("lw_retire", retire, 1'b1);
        tick(); #1;
        chk("lw_ir_once", 4'(ir_cnt - ir_base), 4'd1);
        chk("lw_back_fetch", state, 4'd0);

        // BNE: 3 cycles
        fetch("bne");
        opcode = 6'b000101; #1;
        tick(); #1;
        chk("bne_state", state, 4'd9);
        chk("bne_cond", br_cond, 3'b001);
        chk("bne_pwc", pc_write_cond, 1'b1);
        chk("bne_pcsrc", pc_source, 2'b01);
        chk("bne_aluop", alu_op, 2'b01);
        chk("bne_retire", retire, 1'b1);
        tick(); #1;
        chk("bne_back_fetch", state, 4'd0);

        // JAL
        fetch("jal");
        opcode = 6'b000011; #1;
        tick(); #1;
        chk("jal_state", state, 4'd10);
        chk("jal_dst", reg_dst, 2'b10);
        chk("jal_m2r", mem_to_reg, 2'b10);
        chk("jal_pcsrc", pc_source, 2'b10);
        chk("jal_regw", reg_write, 1'b1);
        tick();

        // SB: byte store, retire on mem_ready
        fetch("sb");
        opcode = 6'b101000; #1;
        tick(); tick(); #1;
        chk("sb_mem_wr", state, 4'd6);
        chk("sb_memw", mem_write, 1'b1);
        chk("sb_memr", mem_read, 1'b0);
        chk("sb_byte", mem_byte, 1'b1);
        chk("sb_retire", retire, 1'b1);
        tick();

        // Unknown opcode
        fetch("ill");
        opcode = 6'b111111; #1;
        chk("ill_pulse", illegal, 1'b1);
        chk("ill_noretire", retire, 1'b0);
        tick(); #1;
        chk("ill_back_fetch", state, 4'd0);
        chk("ill_clear", illegal, 1'b0);

        // MULT
        fetch("mult");
        opcode = 6'b000000; funct = 6'b011000; #1;
`ifdef MIPS_MULDIV_EN
        chk("mult_dec_noill", illegal, 1'b0);
        tick();
        md_done = 1'b1; #1;
        chk("mult_state", state, 4'd11);
        chk("mult_start", md_start, 1'b1);
        chk("mult_early_done_ignored", retire, 1'b0);
        tick();
        md_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("mult_wait_nostart", md_start, 1'b0);
            chk("mult_wait_noretire", retire, 1'b0);
            tick();
        end
        md_done = 1'b1; #1;
        chk("mult_done_retire", retire, 1'b1);
        chk("mult_done_noregw", reg_write, 1'b0);
        tick();
        md_done = 1'b0; #1;
        chk("mult_back_fetch", state, 4'd0);
`else
        chk("mult_illegal", illegal, 1'b1);
        tick(); #1;
        chk("mult_back_fetch", state, 4'd0);
`endif

        // SW aborted by async reset while in MEM_WR
        fetch("sw");
        opcode = 6'b101011; funct = '0; #1;
        tick(); tick();
        mem_ready = 1'b0; #1;
        chk("sw_mem_wr", state, 4'd6);
        chk("sw_memw", mem_write, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("sw_rst_state", state, 4'd0);
        chk("sw_rst_memw", mem_write, 1'b0);
        chk("sw_rst_retire", retire, 1'b0);
        chk("sw_rst_memr", mem_read, 1'b1);
        @(negedge clk); rst_n = 1'b1;
        tick();

        // SYSCALL halts until reset
        fetch("sys");
        opcode = 6'b000000; funct = 6'b001100; #1;
        tick();
        for (int i = 0; i < 20; i++) begin
            opcode = 6'($urandom); funct = 6'($urandom); #1;
            chk("halt_level", halted, 1'b1);
            chk("halt_state", state, 4'd12);
            chk("halt_memr", mem_read, 1'b0);
            tick();
        end
        rst_n = 1'b0; #1;
        chk("halt_rst_clear", halted, 1'b0);
        chk("halt_rst_state", state, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multi-cycle control FSM for the MIPS core. It sequences fetch, decode, execute, memory and writeback over the shared single-port memory, ALU and register file, with one instruction in flight at a time. It turns the instruction's opcode/funct fields into per-cycle datapath strobes and stalls on memory and multiply/divide handshakes. It sits between the instruction register and the datapath mux/enable network.

## Interface
- No parameters; encodings come from the shared package.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `opcode` in 6: IR[31:26]; sampled only in DECODE.
- `funct` in 6: IR[5:0]; sampled only in DECODE.
- `mem_ready` in 1: memory completes the current access this cycle.
- `md_done` in 1: mul/div unit finished; present only with MULDIV_EN.
- `md_start` out 1: one-cycle start pulse; present only with MULDIV_EN.
- `pc_write`, `pc_write_cond` out 1 each: unconditional / branch-qualified PC update.
- `pc_source` out 2: 00 ALU result, 01 ALUOut (branch target), 10 jump target, 11 rs.
- `i_or_d` out 1: memory address select, 0 PC / 1 ALUOut.
- `mem_read`, `mem_write` out 1 each; `mem_byte` out 1: byte access (LB/SB).
- `ir_write` out 1: load the instruction register.
- `reg_write` out 1.
- `reg_dst` out 2: 00 rt, 01 rd, 10 $31.
- `mem_to_reg` out 2: 00 ALUOut, 01 MDR, 10 PC.
- `alu_src_a` out 1: 0 PC / 1 rs.
- `alu_src_b` out 2: 00 rt, 01 const 4, 10 sign-ext imm, 11 imm<<2.
- `alu_op` out 2: 00 add, 01 compare/sub, 10 decode funct, 11 decode opcode.
- `br_cond` out 3: 000 EQ, 001 NE, 010 LEZ, 011 GTZ, 100 GEZ.
- `retire` out 1: one-cycle pulse when an instruction completes.
- `illegal` out 1: one-cycle pulse when an unknown opcode/funct is decoded.
- `halted` out 1: level; high in HALT.
- `state` out 4: current state, for debug.

## Operation
- States: FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_MEM, WB_ALU, BRANCH, JUMP, MULDIV, HALT.
- **FETCH:** `mem_read`=1, `i_or_d`=0.
  - Hold FETCH while `mem_ready`=0.
  - On the `mem_ready` cycle: `ir_write`=1, `pc_write`=1, `alu_src_a`=0, `alu_src_b`=01, `pc_source`=00, then go to DECODE.
- **DECODE:** `alu_src_b`=11, `alu_op`=00 (precompute branch target). Next state:
  - R-type (000000) with funct JR (001000) → JUMP.
  - SYSCALL (001100) → HALT.
  - MULT (011000) or DIV (011010) → MULDIV.
  - Any other R-type → EXEC_R.
  - ADDI/ADDIU/SLTI/ANDI/ORI/XORI/LUI → EXEC_I.
  - LW/LB/SW/SB → MEM_ADDR.
  - BEQ/BNE/BLEZ/BGTZ/BGEZ → BRANCH.
  - J/JAL → JUMP.
  - Anything else → pulse `illegal` and return to FETCH; no `retire`.
- **EXEC_R:** `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10 → WB_ALU with `reg_dst`=01.
- **EXEC_I:** `alu_src_a`=1, `alu_src_b`=10, `alu_op`=11 → WB_ALU with `reg_dst`=00.
- **WB_ALU:** `reg_write`=1, `mem_to_reg`=00, `retire`=1 → FETCH.
- **MEM_ADDR:** `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00 → MEM_RD (loads) or MEM_WR (stores).
- **MEM_RD / MEM_WR:** `i_or_d`=1, `mem_read`/`mem_write` held, `mem_byte`=1 for LB/SB; wait for `mem_ready`.
  - Loads then go to WB_MEM.
  - Stores pulse `retire` on the `mem_ready` cycle and go to FETCH.
- **WB_MEM:** `reg_write`=1, `mem_to_reg`=01, `reg_dst`=00, `retire`=1 → FETCH.
- **BRANCH:** `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_write_cond`=1, `pc_source`=01, `br_cond` from opcode, `retire`=1 → FETCH.
- **JUMP:** `pc_write`=1, `retire`=1 → FETCH.
  - J: `pc_source`=10.
  - JAL: `pc_source`=10, plus `reg_write`=1, `reg_dst`=10, `mem_to_reg`=10.
  - JR: `pc_source`=11.
- **HALT:** absorbing until reset; all strobes 0, `halted`=1.
- Opcode/funct class is latched in DECODE; later states never re-read `opcode`/`funct`.

## Timing
- All outputs are Moore (functions of state plus latched class), except FETCH/MEM_* strobes, which are qualified by `mem_ready`.
- Reset (async): state=FETCH; every output 0 except `mem_read`=1, which follows FETCH immediately.
- Reset mid-instruction aborts the instruction without `retire` or `reg_write`.
- Cycles with zero-wait memory:
  - R/I-type ALU: 4
  - LW/LB: 5
  - SW/SB: 4
  - Branch or jump: 3
  - Each cycle of `mem_ready`=0 adds one cycle.
- `mem_read` and `mem_write` are never high in the same cycle.
- `retire` and `illegal` are single-cycle and mutually exclusive.

## Configuration
- `MIPS_MULDIV_EN` defined:
  - MULDIV state asserts `md_start` for its first cycle only.
  - It then waits for `md_done` (checked from the cycle after `md_start`), pulses `retire` and goes to FETCH.
  - No `reg_write`; HI/LO are owned by the unit.
- `MIPS_MULDIV_EN` undefined:
  - `md_start`/`md_done` ports are absent.
  - MULT/DIV decode as illegal.

## Structure
- Shared package `mips_ctrl_pkg`:
  - state enum
  - opcode and funct localparams
  - `pc_source`, `alu_op`, `alu_src_b`, `reg_dst`, `mem_to_reg` and `br_cond` encodings
  - the instruction-class enum
- One sub-module, `mips_instr_classify`: combinational opcode/funct → class + `br_cond` + `mem_byte`. The FSM latches its output in DECODE.

## Test plan
- Reset, then ADD (opcode 000000, funct 100000) with `mem_ready`=1 → states FETCH,DECODE,EXEC_R,WB_ALU; `reg_write`=1 with `reg_dst`=01 in cycle 4; one `retire`.
- LW (100011) with `mem_ready` low for 2 cycles in FETCH and 1 cycle in MEM_RD → total 8 cycles; `ir_write` exactly once; `mem_to_reg`=01.
- BNE (000101) → 3 cycles; `br_cond`=001 and `pc_write_cond`=1 in BRANCH. JAL (000011) → `reg_dst`=10, `mem_to_reg`=10, `pc_source`=10.
- Opcode 111111 → `illegal` pulse in DECODE, back to FETCH, no `retire`. SYSCALL → `halted`=1, held for 20 cycles until `rst_n` drops.
- `rst_n` asserted during MEM_WR of SW → immediate FETCH, `mem_write`=0 with no clock edge, no `retire`.
- With `MIPS_MULDIV_EN`: MULT, `md_done` after 5 cycles → single `md_start`, `retire` on the `md_done` cycle. Without the macro: MULT → `illegal`.
